// File: rtl/dino_collision_ctrl.sv
// Game controller for the 7x5 dino runner: collision detection, lives, hit hold, BCD score, composite frame.
// Optional HIGH_SCORE_EN adds a best_score register and port.
module dino_collision_ctrl #(
    parameter int LIVES    = 3,
    parameter int HIT_HOLD = 2
) (
    input  logic        slow_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [34:0] rock_flat,
    input  logic [34:0] dino_flat,
    output logic [34:0] frame_flat,
    output logic        running,
    output logic        game_over,
    output logic        hit,
    output logic [1:0]  lives,
    output logic [15:0] score
`ifdef HIGH_SCORE_EN
    ,
    output logic [15:0] best_score
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, OVER} state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [2:0] HOLD_INIT  = 3'(HIT_HOLD);

    state_t      state, state_n;
    logic [34:0] frame_n;
    logic        hit_n;
    logic [1:0]  lives_n;
    logic [15:0] score_n;
    logic [4:0]  row7_prev;
    logic [2:0]  hold_cnt, hold_n;
    logic        coll, exit_evt;

    // Saturating 4-digit BCD increment: 9999 sticks, otherwise ripple the carry.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign coll     = |(rock_flat & dino_flat);
    assign exit_evt = (row7_prev != 5'd0) && (rock_flat[34:30] == 5'd0);

    always_comb begin
        state_n = state;
        frame_n = frame_flat;
        hit_n   = 1'b0;
        lives_n = lives;
        score_n = score;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                frame_n = rock_flat | dino_flat;
                if (coll) begin
                    hit_n   = 1'b1;
                    lives_n = lives - 2'd1;
                    if (lives_n == 2'd0) begin
                        state_n = OVER;
                    end else begin
                        state_n = HOLD;
                        hold_n  = HOLD_INIT;
                    end
                end else if (exit_evt) begin
                    score_n = bcd_inc_sat(score);
                end
            end
            HOLD: begin
                frame_n = rock_flat | dino_flat;
                if (exit_evt) score_n = bcd_inc_sat(score);
                // hold_cnt counts the HOLD cycles still to be spent, including this one.
                if (hold_cnt <= 3'd1) begin
                    state_n = RUN;
                    hold_n  = 3'd0;
                end else begin
                    hold_n = hold_cnt - 3'd1;
                end
            end
            OVER: begin
                if (start) begin
                    state_n = RUN;
                    score_n = 16'h0000;
                    lives_n = LIVES_INIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_flat <= '0;
            running    <= 1'b0;
            game_over  <= 1'b0;
            hit        <= 1'b0;
            lives      <= LIVES_INIT;
            score      <= '0;
            row7_prev  <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            frame_flat <= frame_n;
            running    <= (state_n == RUN) || (state_n == HOLD);
            game_over  <= (state_n == OVER);
            hit        <= hit_n;
            lives      <= lives_n;
            score      <= score_n;
            row7_prev  <= rock_flat[34:30];
            hold_cnt   <= hold_n;
        end
    end

`ifdef HIGH_SCORE_EN
    // Score cannot change on the fatal edge, so the current score is the final one.
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            best_score <= '0;
        end else if (state == RUN && state_n == OVER && score > best_score) begin
            best_score <= score;
        end
    end
`endif

endmodule

// File: tb/tb_dino_collision_ctrl.sv
// Directed bench for dino_collision_ctrl: vector table plus hand-written multi-cycle sequences.
// Compile with +define+HIGH_SCORE_EN to also cover best_score.
module tb_dino_collision_ctrl;

    logic        slow_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [34:0] rock_flat, dino_flat;
    logic [34:0] frame_flat;
    logic        running, game_over, hit;
    logic [1:0]  lives;
    logic [15:0] score;
`ifdef HIGH_SCORE_EN
    logic [15:0] best_score;
`endif

    dino_collision_ctrl #(.LIVES(3), .HIT_HOLD(2)) dut (
        .slow_clk   (slow_clk),
        .reset      (reset),
        .start      (start),
        .rock_flat  (rock_flat),
        .dino_flat  (dino_flat),
        .frame_flat (frame_flat),
        .running    (running),
        .game_over  (game_over),
        .hit        (hit),
        .lives      (lives),
        .score      (score)
`ifdef HIGH_SCORE_EN
        ,
        .best_score (best_score)
`endif
    );

    always #5 slow_clk = ~slow_clk;

    localparam logic [34:0] R7 = 35'h1 << 30;
    localparam logic [34:0] B0 = 35'h1;
    localparam logic [34:0] Z  = 35'h0;

    typedef struct {
        logic        start;
        logic [34:0] rock;
        logic [34:0] dino;
        logic        chk_frame;
        logic [34:0] frame;
        logic        run;
        logic        go;
        logic        hit;
        logic [1:0]  lives;
        logic [15:0] score;
    } vec_t;

    vec_t vecs[15];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic [34:0] r, input logic [34:0] d);
        start     = st;
        rock_flat = r;
        dino_flat = d;
        @(posedge slow_clk);
        #1;
    endtask

    task automatic do_exit();
        step(1'b0, R7, Z);
        step(1'b0, Z, Z);
    endtask

    // Three collisions spaced past the two-cycle hold; ends in OVER.
    task automatic end_game();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, B0, B0);
            check("end_game_hit", hit, 1'b1);
            if (k < 2) begin
                step(1'b0, Z, Z);
                step(1'b0, Z, Z);
            end
        end
        check("end_game_over", game_over, 1'b1);
        check("end_game_running", running, 1'b0);
    endtask

    initial begin
        //           start rock     dino chk frame run go hit lives score
        vecs[0]  = '{1'b1, Z,       Z,   1, Z,       1, 0, 0, 2'd3, 16'h0000};
        vecs[1]  = '{1'b0, R7,      Z,   1, R7,      1, 0, 0, 2'd3, 16'h0000};
        vecs[2]  = '{1'b0, Z,       Z,   1, Z,       1, 0, 0, 2'd3, 16'h0001};
        vecs[3]  = '{1'b0, B0,      B0,  1, B0,      1, 0, 1, 2'd2, 16'h0001};
        vecs[4]  = '{1'b0, B0,      B0,  1, B0,      1, 0, 0, 2'd2, 16'h0001};
        vecs[5]  = '{1'b0, B0,      B0,  1, B0,      1, 0, 0, 2'd2, 16'h0001};
        vecs[6]  = '{1'b0, Z,       B0,  1, B0,      1, 0, 0, 2'd2, 16'h0001};
        vecs[7]  = '{1'b0, R7,      Z,   1, R7,      1, 0, 0, 2'd2, 16'h0001};
        vecs[8]  = '{1'b0, B0,      B0,  1, B0,      1, 0, 1, 2'd1, 16'h0001};
        vecs[9]  = '{1'b0, R7,      Z,   1, R7,      1, 0, 0, 2'd1, 16'h0001};
        vecs[10] = '{1'b0, Z,       Z,   1, Z,       1, 0, 0, 2'd1, 16'h0002};
        vecs[11] = '{1'b0, B0|R7,   B0,  1, B0|R7,   0, 1, 1, 2'd0, 16'h0002};
        vecs[12] = '{1'b0, Z,       Z,   1, B0|R7,   0, 1, 0, 2'd0, 16'h0002};
        vecs[13] = '{1'b1, Z,       Z,   0, Z,       1, 0, 0, 2'd3, 16'h0000};
        vecs[14] = '{1'b1, Z,       Z,   1, Z,       1, 0, 0, 2'd3, 16'h0000};

        reset     = 1'b1;
        start     = 1'b0;
        rock_flat = Z;
        dino_flat = Z;
        #2;
        check("rst_lives", lives, 2'd3);
        check("rst_score", score, 16'h0000);
        check("rst_frame", frame_flat, Z);
        check("rst_running", running, 1'b0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_hit", hit, 1'b0);
`ifdef HIGH_SCORE_EN
        check("rst_best", best_score, 16'h0000);
`endif
        #10 reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].start, vecs[i].rock, vecs[i].dino);
            if (vecs[i].chk_frame) check($sformatf("v%0d_frame", i), frame_flat, vecs[i].frame);
            check($sformatf("v%0d_running", i), running, vecs[i].run);
            check($sformatf("v%0d_game_over", i), game_over, vecs[i].go);
            check($sformatf("v%0d_hit", i), hit, vecs[i].hit);
            check($sformatf("v%0d_lives", i), lives, vecs[i].lives);
            check($sformatf("v%0d_score", i), score, vecs[i].score);
`ifdef HIGH_SCORE_EN
            if (i == 11) check("v11_best", best_score, 16'h0002);
`endif
        end

        // Game ending at 0005, then a shorter one ending at 0003.
        for (int k = 0; k < 5; k++) do_exit();
        check("g5_score", score, 16'h0005);
        end_game();
        check("g5_final_score", score, 16'h0005);
`ifdef HIGH_SCORE_EN
        check("g5_best", best_score, 16'h0005);
`endif
        step(1'b1, Z, Z);
        check("g3_restart_running", running, 1'b1);
        check("g3_restart_lives", lives, 2'd3);
        for (int k = 0; k < 3; k++) do_exit();
        end_game();
        check("g3_final_score", score, 16'h0003);
`ifdef HIGH_SCORE_EN
        check("g3_best", best_score, 16'h0005);
`endif
        step(1'b1, Z, Z);
        check("bcd_restart_score", score, 16'h0000);

        // BCD carry from 0009 to 0010.
        for (int k = 0; k < 9; k++) do_exit();
        check("bcd_0009", score, 16'h0009);
        do_exit();
        check("bcd_0010", score, 16'h0010);

        // Tie-break: collision on the same edge as an exit.
        step(1'b0, R7, Z);
        step(1'b0, B0, B0);
        check("tie_hit", hit, 1'b1);
        check("tie_score", score, 16'h0010);
        step(1'b0, Z, Z);
        step(1'b0, Z, Z);
        check("tie_back_running", running, 1'b1);

        // Run the score up to 9999 and confirm it saturates.
        for (int k = 0; k < 9989; k++) do_exit();
        check("sat_9999", score, 16'h9999);
        do_exit();
        check("sat_hold", score, 16'h9999);
        check("sat_lives", lives, 2'd2);

        // Asynchronous reset mid-RUN, observed before the next edge.
        step(1'b0, B0, Z);
        #2 reset = 1'b1;
        #1;
        check("arst_running", running, 1'b0);
        check("arst_score", score, 16'h0000);
        check("arst_lives", lives, 2'd3);
        check("arst_frame", frame_flat, Z);
        check("arst_game_over", game_over, 1'b0);
`ifdef HIGH_SCORE_EN
        check("arst_best", best_score, 16'h0000);
`endif
        #1 reset = 1'b0;
        step(1'b0, Z, Z);
        check("arst_idle_running", running, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
